// File: rtl/glitch_sequencer.sv
// Single-shot glitch sequencer: arm latches timing config, a trigger rising edge
// starts an unsigned delay followed by a train of width/gap pulses.
module glitch_sequencer #(
    parameter int DELAY_W  = 64,
    parameter int WIDTH_W  = 32,
    parameter int REPEAT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic                trigger,
    input  logic [DELAY_W-1:0]  cfg_delay,
    input  logic [WIDTH_W-1:0]  cfg_width,
    input  logic [WIDTH_W-1:0]  cfg_gap,
    input  logic [REPEAT_W-1:0] cfg_repeat,
    output logic                glitch_out,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic [REPEAT_W-1:0] pulse_cnt
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;

    state_t              state, state_n;
    logic                trigger_q;
    logic [DELAY_W-1:0]  dly_cnt, dly_cnt_n, delay_l, delay_l_n;
    logic [WIDTH_W-1:0]  cnt, cnt_n, width_l, width_l_n, gap_l, gap_l_n;
    logic [REPEAT_W-1:0] repeat_l, repeat_l_n, pulse_cnt_n;
    logic                glitch_n, done_n, trig_edge;

    assign trig_edge = trigger & ~trigger_q;
    assign armed     = (state == ARMED);
    assign busy      = (state == DELAY) || (state == PULSE) || (state == GAP);

    always_comb begin
        state_n     = state;
        dly_cnt_n   = dly_cnt;
        cnt_n       = cnt;
        delay_l_n   = delay_l;
        width_l_n   = width_l;
        gap_l_n     = gap_l;
        repeat_l_n  = repeat_l;
        pulse_cnt_n = pulse_cnt;
        glitch_n    = glitch_out;
        done_n      = 1'b0;
        if (abort) begin
            // abort outranks arm and trigger; pulse_cnt is left for inspection
            state_n  = IDLE;
            glitch_n = 1'b0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    delay_l_n   = cfg_delay;
                    width_l_n   = (cfg_width  == '0) ? WIDTH_W'(1)  : cfg_width;
                    gap_l_n     = (cfg_gap    == '0) ? WIDTH_W'(1)  : cfg_gap;
                    repeat_l_n  = (cfg_repeat == '0) ? REPEAT_W'(1) : cfg_repeat;
                    pulse_cnt_n = '0;
                    state_n     = ARMED;
                end
                ARMED: if (trig_edge) begin
                    dly_cnt_n = delay_l;
                    state_n   = DELAY;
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        state_n  = PULSE;
                        glitch_n = 1'b1;
                        cnt_n    = width_l - WIDTH_W'(1);
                    end else begin
                        dly_cnt_n = dly_cnt - DELAY_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        glitch_n    = 1'b0;
                        pulse_cnt_n = pulse_cnt + REPEAT_W'(1);
                        if (pulse_cnt + REPEAT_W'(1) == repeat_l) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = GAP;
                            cnt_n   = gap_l - WIDTH_W'(1);
                        end
                    end else begin
                        cnt_n = cnt - WIDTH_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state_n  = PULSE;
                        glitch_n = 1'b1;
                        cnt_n    = width_l - WIDTH_W'(1);
                    end else begin
                        cnt_n = cnt - WIDTH_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            trigger_q  <= 1'b0;
            dly_cnt    <= '0;
            cnt        <= '0;
            delay_l    <= '0;
            width_l    <= '0;
            gap_l      <= '0;
            repeat_l   <= '0;
            pulse_cnt  <= '0;
            glitch_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            trigger_q  <= trigger;
            dly_cnt    <= dly_cnt_n;
            cnt        <= cnt_n;
            delay_l    <= delay_l_n;
            width_l    <= width_l_n;
            gap_l      <= gap_l_n;
            repeat_l   <= repeat_l_n;
            pulse_cnt  <= pulse_cnt_n;
            glitch_out <= glitch_n;
            done       <= done_n;
        end
    end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
- Single-shot glitch controller for the glitcher datapath. Arming it captures the timing configuration. An external trigger edge then starts the sequence.
- Sequence: an unsigned programmable delay, then a train of glitch pulses with programmable width, gap and repeat count.
- Replaces ad-hoc chaining of delay stages. It uses down-counters loaded with unsigned values, so there is no signed wrap-around hazard.

Parameters:
- DELAY_W, 64, width of delay config and delay counter
- WIDTH_W, 32, width of pulse width and gap configs and their counter
- REPEAT_W, 16, width of repeat config and pulse counter

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  one-cycle arm request; accepted only in IDLE
- abort  in  1  force return to IDLE from any state
- trigger  in  1  already-synchronised trigger level; rising edge starts the sequence
- cfg_delay  in  DELAY_W  cycles between trigger edge and first pulse
- cfg_width  in  WIDTH_W  pulse high time in cycles (0 treated as 1)
- cfg_gap  in  WIDTH_W  low time between pulses in cycles (0 treated as 1)
- cfg_repeat  in  REPEAT_W  number of pulses (0 treated as 1)
- glitch_out  out  1  registered glitch drive
- armed  out  1  high in ARMED
- busy  out  1  high in DELAY, PULSE, GAP
- done  out  1  one-cycle pulse at sequence completion
- pulse_cnt  out  REPEAT_W  pulses completed in current or last sequence

Behaviour:
- Reset (rst_n low, async): state IDLE. glitch_out, armed, busy and done are 0. pulse_cnt is 0. All counters, latched configs and trigger_q are 0.
- All outputs are registered. armed and busy are decoded from the state register.
- Edge detect: trigger_q <= trigger every cycle in every state. edge = trigger & ~trigger_q. A trigger already high at arm does not fire until it goes low and then high again.
- IDLE: on arm, latch cfg_* (zero-to-one substitution applied), clear pulse_cnt, go to ARMED. arm in any other state is ignored.
- ARMED: on edge, go to DELAY and load cnt <= delay_l. Otherwise stay.
- DELAY: if cnt == 0, go to PULSE, glitch_out <= 1, cnt <= width_l - 1. Else cnt <= cnt - 1.
  - If the edge is sampled at clock edge E0, glitch_out is first high after edge E0 + delay + 1.
  - delay = 0 gives 1-cycle latency. The full 2^DELAY_W - 1 range is valid.
- PULSE: glitch_out stays high for exactly width_l cycles. When cnt == 0: glitch_out <= 0 and pulse_cnt += 1, then:
  - If pulse_cnt + 1 == repeat_l: done <= 1 for one cycle and go to IDLE.
  - Else go to GAP with cnt <= gap_l - 1.
- GAP: glitch_out stays low for exactly gap_l cycles. When cnt == 0: go to PULSE, glitch_out <= 1, cnt <= width_l - 1.
- Config inputs changing after arm have no effect until the next arm.
- abort has priority over every transition, including arm and edge in the same cycle.
  - Next edge: state IDLE, glitch_out 0, done 0.
  - pulse_cnt holds its value.
  - No done pulse on abort.
- arm and abort in the same cycle: abort wins and the arm is dropped.
- rst_n asserted mid-sequence: glitch_out drops immediately (async).
- Arithmetic is unsigned throughout. Counters only count down and the terminal test is == 0, so counters never wrap.

Test Plan:
- arm with delay=0, width=1, gap=1, repeat=1, then trigger 0→1 sampled at E0 -> glitch_out high for exactly E0+1 only; done high at E0+2; pulse_cnt=1; back to IDLE.
- delay=10, width=3, gap=2, repeat=3, trigger edge at E0 -> glitch_out high in cycles E0+11..13, E0+16..18, E0+21..23; done one cycle with the final fall; pulse_cnt=3.
- cfg_delay=64'hFFFF_FFFF_FFFF_FFF0 plus a backdoor/forced counter near 0 -> pulse still fires after the remaining count; no early fire from signed or wrap effects.
- trigger held high before and through arm -> no start; drop trigger, raise it again -> sequence starts from the second rising edge.
- abort during the second PULSE of repeat=4 -> glitch_out 0 on the next edge; state IDLE; no done; pulse_cnt=1; a new arm works normally.
- rst_n low during DELAY -> all outputs 0 immediately; after release, trigger edges are ignored until the next arm; cfg width=0, gap=0, repeat=0 after arm -> a single 1-cycle pulse.
